// File: rtl/wb_master_mux.sv
// Wishbone master-side multiplexer: routes the granted master onto a shared
// slave port, forwards responses and aborts transfers the slave never answers.
module wb_master_mux #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          grant_i,
    input  logic [3:0]          m_stb_i,
    input  logic [3:0]          m_we_i,
    input  logic [4*AW-1:0]     m_adr_i,
    input  logic [4*DW-1:0]     m_dat_i,
    input  logic [4*(DW/8)-1:0] m_sel_i,
    output logic [3:0]          m_ack_o,
    output logic [3:0]          m_err_o,
    output logic [DW-1:0]       m_dat_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    output logic [DW/8-1:0]     s_sel_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    output logic                busy_o,
    output logic [7:0]          to_count_o,
    output logic                grant_fault_o
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        TOERR,
        DRAIN
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] own_q, own_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       fault_q, fault_d;

    logic [1:0]    low_idx;
    logic          multi_grant;
    logic          own_grant;
    logic          own_stb;
    logic          resp;
    logic          wait_hit;

    // Lowest set grant bit picks the owner when several are raised.
    always_comb begin
        low_idx = 2'd0;
        unique casez (grant_i)
            4'b???1: low_idx = 2'd0;
            4'b??10: low_idx = 2'd1;
            4'b?100: low_idx = 2'd2;
            4'b1000: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
    end

    assign multi_grant = (grant_i & (grant_i - 4'd1)) != 4'd0;
    assign own_grant   = grant_i[own_q];
    assign own_stb     = own_grant & m_stb_i[own_q];
    assign resp        = s_ack_i | s_err_i;

    // Timeout fires on the stb cycle that would bring the counter to TIMEOUT.
    assign wait_hit = ({1'b0, cnt_q} + 9'd1) >= 9'(TIMEOUT);

    assign m_dat_o       = s_dat_i;
    assign to_count_o    = to_cnt_q;
    assign grant_fault_o = fault_q;

    // Slave-side and master-response outputs; everything is quiet during reset.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = 4'd0;
        m_err_o = 4'd0;
        busy_o  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                BUSY: begin
                    busy_o         = 1'b1;
                    s_cyc_o        = own_grant;
                    s_stb_o        = own_stb;
                    s_we_o         = m_we_i[own_q];
                    s_adr_o        = m_adr_i[own_q*AW +: AW];
                    s_dat_o        = m_dat_i[own_q*DW +: DW];
                    s_sel_o        = m_sel_i[own_q*SW +: SW];
                    m_ack_o[own_q] = s_ack_i & own_stb;
                    m_err_o[own_q] = s_err_i & own_stb;
                end
                TOERR: m_err_o[own_q] = 1'b1;
                default: ;
            endcase
        end
    end

    // Next-state, owner latch, wait counter and status counters.
    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        cnt_d    = 8'd0;
        to_cnt_d = to_cnt_q;
        fault_d  = fault_q | multi_grant;
        unique case (state_q)
            IDLE: begin
                if (grant_i != 4'd0) begin
                    own_d   = low_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!own_grant) begin
                    state_d = IDLE;
                end else if (own_stb && !resp) begin
                    if (wait_hit) state_d = TOERR;
                    else          cnt_d   = cnt_q + 8'd1;
                end
            end
            TOERR: begin
                state_d = DRAIN;
                if (to_cnt_q != 8'hff) to_cnt_d = to_cnt_q + 8'd1;
            end
            DRAIN: begin
                if (!own_grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            own_q    <= 2'd0;
            cnt_q    <= 8'd0;
            to_cnt_q <= 8'd0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            cnt_q    <= cnt_d;
            to_cnt_q <= to_cnt_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_wb_master_mux.sv
// Bench for wb_master_mux: directed scenarios then random traffic,
// all checked against a transaction-level reference model.
module tb_wb_master_mux;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      grant_i, m_stb_i, m_we_i;
    logic [4*AW-1:0] m_adr_i;
    logic [4*DW-1:0] m_dat_i;
    logic [4*SW-1:0] m_sel_i;
    logic [3:0]      m_ack_o, m_err_o;
    logic [DW-1:0]   m_dat_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [SW-1:0]   s_sel_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i;
    logic            busy_o;
    logic [7:0]      to_count_o;
    logic            grant_fault_o;

    int checks = 0;
    int failures = 0;

    wb_master_mux #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .grant_i(grant_i), .m_stb_i(m_stb_i),
        .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_sel_i(m_sel_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_dat_o(m_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .busy_o(busy_o), .to_count_o(to_count_o),
        .grant_fault_o(grant_fault_o)
    );

    always #5 clk = ~clk;

    // Reference model: a transaction is either in flight, in its one-cycle
    // timeout abort, or waiting for the master to release its grant.
    bit       in_xfer  = 0;
    bit       abort    = 0;
    bit       draining = 0;
    int       owner    = 0;
    int       waited   = 0;
    int       tos      = 0;
    bit       fault    = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model's view of the current cycle.
    task automatic settle();
        logic [3:0]    e_ack, e_err;
        logic          e_cyc, e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        #4;
        e_ack = 0; e_err = 0; e_cyc = 0; e_stb = 0;
        e_we = 0; e_adr = 0; e_dat = 0; e_sel = 0;
        if (!rst && abort) begin
            e_err[owner] = 1'b1;
        end else if (!rst && in_xfer) begin
            e_cyc = grant_i[owner];
            e_stb = e_cyc && m_stb_i[owner];
            e_we  = m_we_i[owner];
            e_adr = m_adr_i[owner*AW +: AW];
            e_dat = m_dat_i[owner*DW +: DW];
            e_sel = m_sel_i[owner*SW +: SW];
            e_ack[owner] = s_ack_i && e_stb;
            e_err[owner] = s_err_i && e_stb;
        end
        chk("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
        chk("s_stb", 64'(s_stb_o), 64'(e_stb));
        chk("s_we", 64'(s_we_o), 64'(e_we));
        chk("s_adr", 64'(s_adr_o), 64'(e_adr));
        chk("s_dat", 64'(s_dat_o), 64'(e_dat));
        chk("s_sel", 64'(s_sel_o), 64'(e_sel));
        chk("m_ack", 64'(m_ack_o), 64'(e_ack));
        chk("m_err", 64'(m_err_o), 64'(e_err));
        chk("m_dat", 64'(m_dat_o), 64'(s_dat_i));
        chk("busy", 64'(busy_o), 64'(!rst && in_xfer));
        chk("to_count", 64'(to_count_o), 64'(tos));
        chk("fault", 64'(grant_fault_o), 64'(fault));
    endtask

    // Advance the model across the clock edge using the inputs held there.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            in_xfer = 0; abort = 0; draining = 0;
            owner = 0; waited = 0; tos = 0; fault = 0;
        end else begin
            if ($countones(grant_i) > 1) fault = 1;
            if (abort) begin
                abort = 0;
                draining = 1;
                if (tos < 255) tos++;
            end else if (draining) begin
                if (!grant_i[owner]) draining = 0;
            end else if (in_xfer) begin
                if (!grant_i[owner]) begin
                    in_xfer = 0;
                    waited = 0;
                end else if (m_stb_i[owner] && !(s_ack_i || s_err_i)) begin
                    waited++;
                    if (waited >= TO) begin
                        in_xfer = 0;
                        abort = 1;
                        waited = 0;
                    end
                end else begin
                    waited = 0;
                end
            end else if (grant_i != 0) begin
                for (int i = 3; i >= 0; i--)
                    if (grant_i[i]) owner = i;
                in_xfer = 1;
            end
        end
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic randomize_data();
        m_we_i  = 4'($urandom);
        m_adr_i = {$urandom, $urandom, $urandom, $urandom};
        m_dat_i = {$urandom, $urandom, $urandom, $urandom};
        m_sel_i = 16'($urandom);
        s_dat_i = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        grant_i = 0; m_stb_i = 0; m_we_i = 0; m_adr_i = 0;
        m_dat_i = 0; m_sel_i = 0; s_dat_i = 0; s_ack_i = 0; s_err_i = 0;
        @(posedge clk);
        #1;
        do_reset();
        cycle();

        // Master 2 single transfer with same-cycle ack.
        randomize_data();
        grant_i = 4'b0100;
        m_stb_i = 4'b0100;
        m_adr_i[2*AW +: AW] = 32'h1000;
        cycle();
        settle();
        chk("req039_cyc", 64'(s_cyc_o), 64'd1);
        chk("req039_adr", 64'(s_adr_o), 64'h1000);
        tick();
        s_ack_i = 1'b1;
        settle();
        chk("req039_ack", 64'(m_ack_o), 64'b0100);
        tick();
        s_ack_i = 1'b0;
        grant_i = 0;
        m_stb_i = 0;
        cycle();
        cycle();

        // Master 1 timeout, then drain until grant drops.
        grant_i = 4'b0010;
        m_stb_i = 4'b0010;
        repeat (5) cycle();
        settle();
        chk("req040_err", 64'(m_err_o), 64'b0010);
        chk("req040_cyc", 64'(s_cyc_o), 64'd0);
        tick();
        repeat (3) begin
            settle();
            chk("req040_drain", 64'(s_cyc_o), 64'd0);
            chk("req040_cnt", 64'(to_count_o), 64'd1);
            tick();
        end
        grant_i = 0;
        m_stb_i = 0;
        cycle();
        cycle();

        // Ack on the timeout cycle wins.
        grant_i = 4'b0001;
        m_stb_i = 4'b0001;
        repeat (4) cycle();
        s_ack_i = 1'b1;
        settle();
        chk("req041_ack", 64'(m_ack_o), 64'b0001);
        chk("req041_err", 64'(m_err_o), 64'd0);
        tick();
        s_ack_i = 1'b0;
        grant_i = 0;
        cycle();
        settle();
        chk("req041_cnt", 64'(to_count_o), 64'd1);
        tick();

        // Multiple grants: lowest wins, sticky fault.
        grant_i = 4'b1001;
        m_stb_i = 4'b1001;
        randomize_data();
        cycle();
        grant_i = 4'b0001;
        repeat (3) begin
            settle();
            chk("req042_fault", 64'(grant_fault_o), 64'd1);
            chk("req042_adr", 64'(s_adr_o), 64'(m_adr_i[AW-1:0]));
            tick();
        end

        // Reset mid-transfer.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        settle();
        chk("req043_busy", 64'(busy_o), 64'd0);
        chk("req043_cnt", 64'(to_count_o), 64'd0);
        tick();

        // Grant drop mid-stb.
        grant_i = 4'b1000;
        m_stb_i = 4'b1000;
        repeat (3) cycle();
        grant_i = 0;
        s_ack_i = 1'b1;
        settle();
        chk("req044_cyc", 64'(s_cyc_o), 64'd0);
        chk("req044_ack", 64'(m_ack_o), 64'd0);
        tick();
        s_ack_i = 1'b0;
        cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            randomize_data();
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 7) == 0) grant_i = 4'($urandom);
                else grant_i = 4'b0001 << $urandom_range(0, 3);
            end
            if ($urandom_range(0, 15) == 0) grant_i = 0;
            m_stb_i = 4'($urandom) | ($urandom_range(0, 1) ? grant_i : 4'd0);
            s_ack_i = ($urandom_range(0, 4) == 0);
            s_err_i = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
